// File: rtl/sub_3op_serial.sv
`default_nettype none
// ==========================================================================
// sub_3op_serial : digit-serial D = A - B - C - Bin, DIGIT bits per clock.
// Revision 1.0
// ==========================================================================
module sub_3op_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   C,
  input  logic               Bin,
  output logic               busy,
  output logic               done,
  output logic [WIDTH+1:0]   D,
  output logic               neg,
  output logic               zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] C_LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       br_q, br_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH+1:0] d_q, d_d;

  logic [DIGIT+1:0]       w_slice_diff;
  logic [1:0]             w_borrow_nxt;
  logic [WIDTH+DIGIT-1:0] w_res_shift;
  logic [WIDTH-1:0]       w_res_nxt;

  // Borrow between slices ranges 0..2 (two subtrahends plus the incoming borrow).
  assign w_slice_diff = {2'b00, a_q[DIGIT-1:0]} - {2'b00, b_q[DIGIT-1:0]}
                      - {2'b00, c_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, br_q};
  assign w_borrow_nxt = 2'b00 - w_slice_diff[DIGIT+1:DIGIT];
  assign w_res_shift  = {w_slice_diff[DIGIT-1:0], res_q};
  assign w_res_nxt    = w_res_shift[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      br_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      br_q    <= br_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    br_d    = br_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = C;
          br_d    = {1'b0, Bin};
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = c_q >> DIGIT;
        br_d  = w_borrow_nxt;
        res_d = w_res_nxt;
        idx_d = idx_q + IW'(1);
        if (idx_q == C_LAST) begin
          // Final borrow of 0/1/2 becomes the two sign bits 00/11/10.
          d_d     = {2'b00 - w_borrow_nxt, w_res_nxt};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign D    = d_q;
  assign neg  = d_q[WIDTH+1];
  assign zero = (d_q == '0);

endmodule
`default_nettype wire
